// File: rtl/fifo_pkg.sv
// Shared FIFO types and constants: word format, depth, thresholds and drain FSM states.
// No logic; imported by the FIFO interface, the drain controller and its skid buffer.
// Drain defaults are overridable through fifo_drain_ctrl parameters.
package fifo_pkg;

  localparam int BIT_DEPTH    = 4;
  localparam int WORD_W       = 8;
  localparam int ALMOST_EMPTY = 2;

  typedef logic [WORD_W-1:0] word_t;

  localparam int DRAIN_BURST_LEN = 4;
  localparam int DRAIN_TIMEOUT   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

endpackage

// File: rtl/fifo_if.sv
// Connection bundle between a show-ahead FIFO slave and its reader/writer.
// No latency of its own; data_out is the head word whenever empty is low.
// The master may only pop; the producer side owns push/data_in.
interface fifo_if;
  import fifo_pkg::*;

  logic  push;
  logic  pop;
  word_t data_in;
  word_t data_out;
  logic  empty;
  logic  almost_empty;
  logic  error;

  modport fmaster_if (
    output pop,
    input  data_out,
    input  empty,
    input  almost_empty,
    input  error
  );

  modport fslave_if (
    input  push,
    input  pop,
    input  data_in,
    output data_out,
    output empty,
    output almost_empty,
    output error
  );

endinterface

// File: rtl/out_skid2.sv
// Two-entry valid/ready skid buffer; head entry drives out_data directly.
// Latency: a word written at edge N is presented from cycle N+1.
// Writes are taken when not full or when the head leaves in the same cycle; cnt lets the writer throttle.
module out_skid2
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  word_t      in_data,
  output logic       out_valid,
  output word_t      out_data,
  input  logic       out_ready,
  output logic [1:0] cnt
);

  logic [1:0] cnt_q, cnt_d;
  word_t      head_q, head_d;
  word_t      tail_q, tail_d;
  logic       wr;
  logic       rd;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign cnt       = cnt_q;

  assign rd = out_valid && out_ready;
  assign wr = in_valid && ((cnt_q != 2'd2) || rd);

  // Next-state of the two slots: head always holds the oldest word.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({wr, rd})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
      end
      2'b01: begin
        cnt_d  = cnt_q - 2'd1;
        head_d = tail_q;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  // Slot and occupancy registers; reset discards any held words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

`ifndef SYNTHESIS
  a_cnt_range: assert property (@(posedge clk) disable iff (!reset_n) cnt_q <= 2'd2);
`endif

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a show-ahead FIFO in fixed bursts when occupancy is high, or flushes lingering words after an idle timeout.
// Latency: word popped at edge N appears on m_data from cycle N+1 (via 2-entry skid).
// Backpressure: m_ready low fills the skid; pops stop at two held words and resume as space frees.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int BURST_LEN = DRAIN_BURST_LEN,
  parameter int TIMEOUT   = DRAIN_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_n,
  fifo_if.fmaster_if f_if,
  input  logic       enable,
  output logic       m_valid,
  output word_t      m_data,
  input  logic       m_ready,
  output logic       busy,
  output logic       short_burst,
  output logic       err_sticky,
  input  logic       clr_err
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(BURST_LEN);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  drain_state_t  state_q;
  logic [BW-1:0] burst_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic          short_q;
  logic          err_q;
  logic [1:0]    skid_cnt;
  logic          pop;

  // Popping is gated on the registered skid count, so an empty FIFO is never popped
  // and the skid never overflows even if the consumer stalls in the same cycle.
  assign pop = ((state_q == BURST) || (state_q == FLUSH)) && enable
               && !f_if.empty && (skid_cnt < 2'd2);

  assign f_if.pop    = pop;
  assign busy        = (state_q != IDLE);
  assign short_burst = short_q;
  assign err_sticky  = err_q;

  out_skid2 u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (pop),
    .in_data   (f_if.data_out),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_ready (m_ready),
    .cnt       (skid_cnt)
  );

  // Drain FSM with burst and idle-timeout counters; short_burst is a registered one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      to_cnt_q    <= '0;
      short_q     <= 1'b0;
    end else begin
      short_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && !f_if.almost_empty) begin
            state_q     <= BURST;
            burst_cnt_q <= '0;
            to_cnt_q    <= '0;
          end else if (enable && !f_if.empty && (to_cnt_q == TO_LAST)) begin
            state_q  <= FLUSH;
            to_cnt_q <= '0;
          end else if (!enable || f_if.empty) begin
            to_cnt_q <= '0;
          end else if (to_cnt_q != TO_LAST) begin
            // Reaching here means enabled, non-empty and at or below the almost-empty mark.
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        BURST: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (pop) begin
            if (burst_cnt_q != BURST_MAX) burst_cnt_q <= burst_cnt_q + 1'b1;
            if (burst_cnt_q == BURST_LAST) state_q <= IDLE;
          end else if (f_if.empty) begin
            state_q <= IDLE;
            short_q <= 1'b1;
          end
          // Otherwise the skid is full: hold and wait for space.
        end
        FLUSH: begin
          if (!enable || f_if.empty) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Sticky error capture; a new error in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (f_if.error) begin
      err_q <= 1'b1;
    end else if (clr_err) begin
      err_q <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
    !(pop && f_if.empty));
  a_data_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (m_valid && !m_ready) |=> $stable(m_data));
  a_state_legal: assert property (@(posedge clk) disable iff (!reset_n)
    state_q inside {IDLE, BURST, FLUSH})
    else $warning("fifo_drain_ctrl: illegal state, returning to IDLE");
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural show-ahead FIFO slave.
// Expected words, pop counts and cycle positions are hand-derived per scenario.
// Outputs are sampled on the falling edge.
module tb_fifo_drain_ctrl;
  import fifo_pkg::*;

  logic  clk = 1'b0;
  logic  reset_n;
  logic  enable;
  logic  m_valid;
  word_t m_data;
  logic  m_ready;
  logic  busy;
  logic  short_burst;
  logic  err_sticky;
  logic  clr_err;

  fifo_if f();

  fifo_drain_ctrl #(.BURST_LEN(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .f_if        (f),
    .enable      (enable),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .busy        (busy),
    .short_burst (short_burst),
    .err_sticky  (err_sticky),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO slave
  word_t      mem [16];
  logic [3:0] rd = 4'd0;
  logic [3:0] wr = 4'd0;
  int         cnt = 0;
  logic       model_clr;

  assign f.empty        = (cnt == 0);
  assign f.almost_empty = (cnt <= ALMOST_EMPTY);
  assign f.data_out     = mem[rd];

  always @(posedge clk) begin
    if (model_clr) begin
      rd  <= 4'd0;
      wr  <= 4'd0;
      cnt <= 0;
    end else begin
      if (f.push) begin
        mem[wr] <= f.data_in;
        wr      <= wr + 4'd1;
      end
      if (f.pop) rd <= rd + 4'd1;
      cnt <= cnt + (f.push ? 1 : 0) - (f.pop ? 1 : 0);
    end
  end

  // Monitor: monotonic counters and accepted-output log
  int    pop_cnt = 0;
  int    pop_empty = 0;
  int    short_cnt = 0;
  word_t outq [$];

  always @(posedge clk) begin
    if (reset_n) begin
      if (f.pop) pop_cnt++;
      if (f.pop && f.empty) pop_empty++;
      if (short_burst) short_cnt++;
      if (m_valid && m_ready) outq.push_back(m_data);
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      f.push    = 1'b1;
      f.data_in = first + 8'(i);
      @(negedge clk);
    end
    f.push = 1'b0;
  endtask

  task automatic reset_all();
    reset_n   = 1'b0;
    model_clr = 1'b1;
    enable    = 1'b0;
    m_ready   = 1'b0;
    cycles(2);
    reset_n   = 1'b1;
    model_clr = 1'b0;
    cycles(1);
  endtask

  task automatic check_out(input string tag, input int base, input int n, input logic [7:0] first);
    chk({tag, "_count"}, outq.size() - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < outq.size()) chk(tag, outq[base + i], first + 8'(i));
  endtask

  int base_p, base_o, base_s, first_pop;

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    m_ready   = 1'b0;
    clr_err   = 1'b0;
    f.push    = 1'b0;
    f.data_in = '0;
    f.error   = 1'b0;
    model_clr = 1'b1;
    cycles(3);

    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_short", short_burst, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_pop", f.pop, 0);
    reset_n   = 1'b1;
    model_clr = 1'b0;
    cycles(1);

    // Burst of 4 from 6 words, cycle-by-cycle
    load(6, 8'hA0);
    base_p = pop_cnt; base_o = outq.size(); base_s = short_cnt;
    m_ready = 1'b1;
    enable  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("burst_pop", f.pop, (k <= 4));
      chk("burst_busy", busy, (k <= 4));
      chk("burst_valid", m_valid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) chk("burst_data", m_data, 8'hA0 + 8'(k - 2));
    end
    enable = 1'b0;
    cycles(2);
    chk("burst_pops", pop_cnt - base_p, 4);
    chk("burst_left", cnt, 2);
    chk("burst_short", short_cnt - base_s, 0);
    check_out("burst_out", base_o, 4, 8'hA0);
    reset_all();

    // Idle-timeout flush of 2 lingering words
    load(2, 8'h11);
    base_p = pop_cnt; base_o = outq.size(); base_s = short_cnt;
    m_ready   = 1'b1;
    enable    = 1'b1;
    first_pop = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (first_pop == 0 && f.pop) first_pop = k;
    end
    chk("to_first_pop_cycle", first_pop, 16);
    chk("to_pops", pop_cnt - base_p, 2);
    chk("to_short", short_cnt - base_s, 0);
    chk("to_empty", f.empty, 1);
    chk("to_busy", busy, 0);
    check_out("to_out", base_o, 2, 8'h11);
    reset_all();

    // Backpressure: skid fills with 2, then releases in order
    load(8, 8'h30);
    base_p = pop_cnt; base_o = outq.size(); base_s = short_cnt;
    m_ready = 1'b0;
    enable  = 1'b1;
    cycles(10);
    chk("bp_pops_stalled", pop_cnt - base_p, 2);
    chk("bp_pop_now", f.pop, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'h30);
    chk("bp_busy", busy, 1);
    cycles(3);
    chk("bp_data_hold", m_data, 8'h30);
    m_ready = 1'b1;
    cycles(30);
    chk("bp_pops_total", pop_cnt - base_p, 8);
    chk("bp_short", short_cnt - base_s, 0);
    chk("bp_empty", f.empty, 1);
    check_out("bp_out", base_o, 8, 8'h30);
    reset_all();

    // Short burst: 3 words pushed with enable already high
    base_p = pop_cnt; base_o = outq.size(); base_s = short_cnt;
    m_ready = 1'b1;
    enable  = 1'b1;
    load(3, 8'h51);
    cycles(12);
    chk("sb_pops", pop_cnt - base_p, 3);
    chk("sb_short_pulses", short_cnt - base_s, 1);
    chk("sb_busy", busy, 0);
    check_out("sb_out", base_o, 3, 8'h51);
    reset_all();

    // Enable drop after 2 pops
    load(6, 8'h60);
    base_p = pop_cnt; base_o = outq.size();
    m_ready = 1'b1;
    enable  = 1'b1;
    cycles(3);
    enable = 1'b0;
    #1;
    chk("en_pop_off", f.pop, 0);
    cycles(6);
    chk("en_pops", pop_cnt - base_p, 2);
    chk("en_valid", m_valid, 0);
    chk("en_busy", busy, 0);
    chk("en_left", cnt, 4);
    check_out("en_out", base_o, 2, 8'h60);

    // Reset mid-burst: skid words lost, FIFO keeps the rest
    m_ready = 1'b0;
    enable  = 1'b1;
    cycles(3);
    chk("rm_busy_before", busy, 1);
    chk("rm_valid_before", m_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("rm_valid", m_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_pop", f.pop, 0);
    cycles(1);
    reset_n = 1'b1;
    base_p = pop_cnt; base_o = outq.size();
    m_ready = 1'b1;
    cycles(30);
    chk("rm_pops_after", pop_cnt - base_p, 2);
    chk("rm_empty", f.empty, 1);
    check_out("rm_out", base_o, 2, 8'h64);
    reset_all();

    // Sticky error
    f.error = 1'b1;
    cycles(1);
    f.error = 1'b0;
    chk("err_set", err_sticky, 1);
    cycles(2);
    chk("err_held", err_sticky, 1);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    chk("err_cleared", err_sticky, 0);
    f.error = 1'b1;
    clr_err = 1'b1;
    cycles(1);
    f.error = 1'b0;
    clr_err = 1'b0;
    chk("err_set_wins", err_sticky, 1);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    chk("err_cleared2", err_sticky, 0);

    chk("pop_while_empty", pop_empty, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
